// File: rtl/sram_controller_if.sv
// Memory-stage request/response bundle for the SRAM controller.
// master: pipeline side (drives requests), slave: controller side.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [63:0] read_pair;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, read_pair, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, read_pair, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Turns single-word loads/stores into WAIT_CYCLES-long SRAM bus cycles.
// Ports: clk, rst (async, high), bus (request/response), SRAM_WE_N/ADDR/DQ.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  output logic                SRAM_WE_N,
  output logic [16:0]         SRAM_ADDR,
  inout  wire  [63:0]         SRAM_DQ
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        cap;
  logic        ready;
  logic [31:0] diff;
  logic [31:0] rd_q;
  logic [63:0] pair_q;
  logic        last;
  logic        unused_ok;

  // Byte offset from the SRAM base; bits [18:2] form the word address.
  assign diff      = bus.address - 32'(BASE_ADDR);
  assign SRAM_ADDR = diff[18:2];
  assign unused_ok = ^{diff[31:19], diff[1:0]};
  assign last      = (cnt == 4'(WAIT_CYCLES - 1));

  // Bus driven only while writing; released in every other state.
  assign SRAM_DQ = SRAM_WE_N ? {64{1'bz}}
                             : {32'b0, bus.write_data};

  assign bus.ready     = ready;
  assign bus.read_data = rd_q;
  assign bus.read_pair = pair_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~(bus.wr_en | bus.rd_en);
        if (bus.wr_en) begin
          state_n = WR_WAIT;
          cnt_n   = 4'd0;
        end else if (bus.rd_en) begin
          state_n = RD_WAIT;
          cnt_n   = 4'd0;
        end
      end
      RD_WAIT: begin
        cnt_n = cnt + 4'd1;
        if (last) begin
          cap     = 1'b1;
          state_n = DONE;
        end
      end
      WR_WAIT: begin
        SRAM_WE_N = 1'b0;
        cnt_n     = cnt + 4'd1;
        if (last) state_n = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rd_q   <= 32'd0;
      pair_q <= 64'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap) begin
        pair_q <= SRAM_DQ;
        rd_q   <= diff[2] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
      end
    end
  end

endmodule
